// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI command decoder / register bus master.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2,
    S_BUSY = 2'd3
  } spi_reg_state_t;

  // Direction bit of the command byte: 1 = write stream, 0 = read stream
  localparam int CMD_W_BIT = 7;

  // Byte shown to the master when a read-stream byte is dropped
  localparam logic [7:0] OVR_FILL = 8'hFF;

endpackage

// File: rtl/spi_reg_bridge.sv
// Decodes the SPI byte stream into register bus reads/writes and supplies
// the next byte for the SPI slave to shift out.
module spi_reg_bridge
  import spi_reg_pkg::*;
#(
  parameter int         ADDR_W    = 7,
  parameter logic [6:0] STATUS_ID = 7'h25
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        mdata,
  input  logic              data_valid_read,
  input  logic              data_firstbyte,
  output logic [7:0]        sdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_wdata,
  input  logic [7:0]        bus_rdata,
  input  logic              bus_ack,
  output logic              overrun
);

  spi_reg_state_t    state_q, state_d, st_now;
  logic              dir_q, dir_d;          // 1 = write stream
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [7:0]        rdbuf_q, rdbuf_d;      // last read data (or overrun fill)
  logic              ovr_q, ovr_d;
  logic              pend_q, pend_d;        // command byte arrived while busy
  logic [7:0]        pcmd_q, pcmd_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [7:0]        bus_wdata_q, bus_wdata_d;

  // Next-state: retire a pending ack first, then treat the byte pulse as if
  // the bus were free (or as an overrun if it is still busy).
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    ptr_d       = ptr_q;
    rdbuf_d     = rdbuf_q;
    ovr_d       = ovr_q;
    pend_d      = pend_q;
    pcmd_d      = pcmd_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    st_now      = state_q;

    if (state_q == S_BUSY && bus_ack) begin
      bus_req_d = 1'b0;
      st_now    = dir_q ? S_WR : S_RD;
      if (!bus_we_q) rdbuf_d = bus_rdata;
      // A command dropped during the busy cycle re-targets the stream but
      // starts no bus cycle and leaves the overrun flag set.
      if (pend_q) begin
        pend_d = 1'b0;
        dir_d  = pcmd_q[CMD_W_BIT];
        ptr_d  = pcmd_q[ADDR_W-1:0];
        st_now = pcmd_q[CMD_W_BIT] ? S_WR : S_RD;
      end
    end
    state_d = st_now;

    if (data_valid_read) begin
      if (st_now == S_BUSY) begin
        ovr_d = 1'b1;
        if (!dir_q) rdbuf_d = OVR_FILL;
        if (data_firstbyte) begin
          pend_d = 1'b1;
          pcmd_d = mdata;
        end
      end else if (data_firstbyte) begin
        dir_d  = mdata[CMD_W_BIT];
        ptr_d  = mdata[ADDR_W-1:0];
        ovr_d  = 1'b0;
        pend_d = 1'b0;
        if (mdata[CMD_W_BIT]) begin
          state_d = S_WR;
        end else begin
          state_d    = S_BUSY;
          bus_req_d  = 1'b1;
          bus_we_d   = 1'b0;
          bus_addr_d = mdata[ADDR_W-1:0];
        end
      end else if (st_now == S_WR) begin
        state_d     = S_BUSY;
        bus_req_d   = 1'b1;
        bus_we_d    = 1'b1;
        bus_addr_d  = ptr_d;
        bus_wdata_d = mdata;
        ptr_d       = ptr_d + 1'b1;
      end else if (st_now == S_RD) begin
        ptr_d      = ptr_d + 1'b1;
        state_d    = S_BUSY;
        bus_req_d  = 1'b1;
        bus_we_d   = 1'b0;
        bus_addr_d = ptr_d;
      end
    end
  end

  // State and bus registers, asynchronously cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      dir_q       <= 1'b0;
      ptr_q       <= '0;
      rdbuf_q     <= 8'h00;
      ovr_q       <= 1'b0;
      pend_q      <= 1'b0;
      pcmd_q      <= 8'h00;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      ptr_q       <= ptr_d;
      rdbuf_q     <= rdbuf_d;
      ovr_q       <= ovr_d;
      pend_q      <= pend_d;
      pcmd_q      <= pcmd_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  // Read streams show captured data; everything else shows the status byte
  assign sdata     = (state_q != S_IDLE && !dir_q) ? rdbuf_q : {ovr_q, STATUS_ID};
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Bench for spi_reg_bridge: vector table, hand sequences for overrun /
// zero-wait / reset, and a randomized run against a transaction-level model.
module tb_spi_reg_bridge;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] mdata;
  logic       dvr, dfb;
  logic [7:0] sdata;
  logic       bus_req, bus_we;
  logic [6:0] bus_addr;
  logic [7:0] bus_wdata, bus_rdata;
  logic       bus_ack;
  logic       overrun;

  spi_reg_bridge dut (
    .clk(clk), .rst(rst), .mdata(mdata), .data_valid_read(dvr),
    .data_firstbyte(dfb), .sdata(sdata), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct { logic we; logic [6:0] a; logic [7:0] d; } op_t;
  typedef struct {
    logic [7:0] b; logic f; int lat; int nops;
    logic we; logic [6:0] a; logic [7:0] d; logic [7:0] sd; logic ov;
  } vec_t;

  op_t        log_q[$];
  logic [7:0] mem [0:127];
  logic [7:0] ref_mem [0:127];
  int         lat = 0;
  int         wcnt = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  // Register-file responder: acks after 'lat' wait cycles, logs completed ops
  always @(negedge clk) begin
    if (bus_ack) wcnt = 0;
    bus_ack = 1'b0;
    if (bus_req && !rst) begin
      if (wcnt >= lat) begin
        bus_ack   = 1'b1;
        bus_rdata = mem[bus_addr];
        if (bus_we) begin
          mem[bus_addr] = bus_wdata;
          log_q.push_back('{we: 1'b1, a: bus_addr, d: bus_wdata});
        end else begin
          log_q.push_back('{we: 1'b0, a: bus_addr, d: mem[bus_addr]});
        end
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pulse(input logic [7:0] b, input logic f);
    mdata = b; dvr = 1'b1; dfb = f;
    @(negedge clk);
    dvr = 1'b0; dfb = 1'b0; mdata = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_ops(input string nm, input int n, input logic we,
                         input logic [6:0] a, input logic [7:0] d);
    op_t o;
    chk({nm, "_nops"}, log_q.size(), n);
    if (n == 1 && log_q.size() == 1) begin
      o = log_q.pop_front();
      chk({nm, "_we"}, o.we, we);
      chk({nm, "_addr"}, o.a, a);
      if (we) chk({nm, "_wdata"}, o.d, d);
    end
    log_q.delete();
  endtask

  function automatic vec_t mkv(logic [7:0] b, logic f, int l, int n, logic we,
                               logic [6:0] a, logic [7:0] d, logic [7:0] sd);
    vec_t v;
    v.b = b; v.f = f; v.lat = l; v.nops = n; v.we = we; v.a = a; v.d = d;
    v.sd = sd; v.ov = 1'b0;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    logic [7:0] b;
    logic       m_dir;
    int         m_ptr;
    int         k;

    // stimulus table: {byte, first, latency, nops, we, addr, wdata, sdata}
    tbl.push_back(mkv(8'h33, 1'b0, 2, 0, 1'b0, 7'd0,   8'h00, 8'h25)); // ignored in IDLE
    tbl.push_back(mkv(8'h85, 1'b1, 2, 0, 1'b0, 7'd0,   8'h00, 8'h25));
    tbl.push_back(mkv(8'h11, 1'b0, 2, 1, 1'b1, 7'd5,   8'h11, 8'h25));
    tbl.push_back(mkv(8'h22, 1'b0, 3, 1, 1'b1, 7'd6,   8'h22, 8'h25));
    tbl.push_back(mkv(8'h33, 1'b0, 1, 1, 1'b1, 7'd7,   8'h33, 8'h25));
    tbl.push_back(mkv(8'hFF, 1'b1, 1, 0, 1'b0, 7'd0,   8'h00, 8'h25));
    tbl.push_back(mkv(8'h01, 1'b0, 1, 1, 1'b1, 7'd127, 8'h01, 8'h25));
    tbl.push_back(mkv(8'h02, 1'b0, 1, 1, 1'b1, 7'd0,   8'h02, 8'h25)); // wrapped
    tbl.push_back(mkv(8'h0A, 1'b1, 3, 1, 1'b0, 7'd10,  8'h00, 8'hA0));
    tbl.push_back(mkv(8'h00, 1'b0, 3, 1, 1'b0, 7'd11,  8'h00, 8'hA1));
    tbl.push_back(mkv(8'h5A, 1'b0, 0, 1, 1'b0, 7'd12,  8'h00, 8'hA2));
    tbl.push_back(mkv(8'h00, 1'b0, 0, 1, 1'b0, 7'd13,  8'h00, 8'hA3));

    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem[10] = 8'hA0; mem[11] = 8'hA1; mem[12] = 8'hA2; mem[13] = 8'hA3;

    rst = 1'b1; mdata = 8'h00; dvr = 1'b0; dfb = 1'b0;
    bus_ack = 1'b0; bus_rdata = 8'h00;
    idle(3);
    chk("rst_sdata", sdata, 8'h25);
    chk("rst_req", bus_req, 1'b0);
    chk("rst_we", bus_we, 1'b0);
    chk("rst_addr", bus_addr, 7'd0);
    chk("rst_wdata", bus_wdata, 8'h00);
    chk("rst_ovr", overrun, 1'b0);
    rst = 1'b0;
    idle(2);

    for (int i = 0; i < tbl.size(); i++) begin
      lat = tbl[i].lat;
      pulse(tbl[i].b, tbl[i].f);
      idle(tbl[i].lat + 4);
      chk_ops($sformatf("vec%0d", i), tbl[i].nops, tbl[i].we, tbl[i].a, tbl[i].d);
      chk($sformatf("vec%0d_sdata", i), sdata, tbl[i].sd);
      chk($sformatf("vec%0d_ovr", i), overrun, tbl[i].ov);
    end

    // zero-wait bus: request one clock wide, data ready one clock later
    lat = 0;
    pulse(8'h0B, 1'b1);
    chk("zw_req_hi0", bus_req, 1'b1);
    idle(1);
    chk("zw_req_lo0", bus_req, 1'b0);
    chk("zw_sdata0", sdata, 8'hA1);
    pulse(8'h00, 1'b0);
    chk("zw_req_hi1", bus_req, 1'b1);
    chk("zw_addr1", bus_addr, 7'd12);
    idle(1);
    chk("zw_req_lo1", bus_req, 1'b0);
    chk("zw_sdata1", sdata, 8'hA2);
    idle(3);
    log_q.delete();

    // overrun: stalled write, second byte dropped, next command clears flag
    lat = 40;
    pulse(8'h85, 1'b1);
    idle(3);
    pulse(8'h44, 1'b0);
    idle(5);
    pulse(8'h55, 1'b0);
    idle(2);
    chk("ovr_flag", overrun, 1'b1);
    chk("ovr_status", sdata, 8'hA5);
    chk("ovr_req_held", bus_req, 1'b1);
    chk("ovr_addr_held", bus_addr, 7'd5);
    chk("ovr_wdata_held", bus_wdata, 8'h44);
    for (k = 0; k < 100 && log_q.size() == 0; k++) @(negedge clk);
    chk("ovr_ack_seen", (log_q.size() != 0), 1'b1);
    idle(4);
    chk_ops("ovr_only_first", 1, 1'b1, 7'd5, 8'h44);
    chk("ovr_sticky", overrun, 1'b1);
    lat = 2;
    pulse(8'h86, 1'b1);
    idle(4);
    chk_ops("ovr_clr", 0, 1'b0, 7'd0, 8'h00);
    chk("ovr_cleared", overrun, 1'b0);
    chk("ovr_status_clr", sdata, 8'h25);

    // asynchronous reset while a request is outstanding
    lat = 1000;
    pulse(8'h83, 1'b1);
    idle(2);
    pulse(8'h77, 1'b0);
    pulse(8'h78, 1'b0);      // also sets overrun before the reset
    idle(2);
    #2 rst = 1'b1;
    #1;
    chk("ar_req", bus_req, 1'b0);
    chk("ar_we", bus_we, 1'b0);
    chk("ar_addr", bus_addr, 7'd0);
    chk("ar_wdata", bus_wdata, 8'h00);
    chk("ar_ovr", overrun, 1'b0);
    chk("ar_sdata", sdata, 8'h25);
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    log_q.delete();
    lat = 1;
    pulse(8'h84, 1'b1);
    idle(4);
    pulse(8'h99, 1'b0);
    idle(5);
    chk_ops("ar_after", 1, 1'b1, 7'd4, 8'h99);

    // randomized streams against a transaction-level model
    for (int i = 0; i < 128; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    log_q.delete();
    m_dir = 1'b1; m_ptr = 0;
    for (int i = 0; i < 80; i++) begin
      lat = int'($urandom_range(0, 5));
      b = 8'($urandom);
      if (i == 0 || $urandom_range(0, 5) == 0) begin
        pulse(b, 1'b1);
        idle(lat + 4);
        m_dir = b[7];
        m_ptr = int'(b[6:0]);
        if (m_dir) begin
          chk_ops($sformatf("rnd%0d_cmdw", i), 0, 1'b0, 7'd0, 8'h00);
          chk($sformatf("rnd%0d_sdata", i), sdata, 8'h25);
        end else begin
          chk_ops($sformatf("rnd%0d_cmdr", i), 1, 1'b0, 7'(m_ptr), 8'h00);
          chk($sformatf("rnd%0d_sdata", i), sdata, ref_mem[m_ptr]);
          m_ptr = (m_ptr + 1) % 128;   // next register the master will see
        end
      end else begin
        pulse(b, 1'b0);
        idle(lat + 4);
        if (m_dir) begin
          chk_ops($sformatf("rnd%0d_wr", i), 1, 1'b1, 7'(m_ptr), b);
          ref_mem[m_ptr] = b;
          chk($sformatf("rnd%0d_sdata", i), sdata, 8'h25);
        end else begin
          chk_ops($sformatf("rnd%0d_rd", i), 1, 1'b0, 7'(m_ptr), 8'h00);
          chk($sformatf("rnd%0d_sdata", i), sdata, ref_mem[m_ptr]);
        end
        m_ptr = (m_ptr + 1) % 128;
      end
      chk($sformatf("rnd%0d_ovr", i), overrun, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
